// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
//   Unsigned NxN multiplier sequencer that time-shares one external 2N-bit
//   combinational adder. It handles one partial product per clock, and the
//   latency is fixed at N RUN cycles plus one DONE cycle.
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, abort    start is accepted only while ready=1; abort cancels a RUN
//   a, b            multiplicand / multiplier, sampled on the accepting edge
//   add_sum         result from the shared adder (add_a + add_b)
//   add_a, add_b    adder operands: accumulator and gated shifted multiplicand
//   ready           high in IDLE only
//   done            one-cycle pulse when product becomes valid
//   product         registered 2N-bit result, held until the next accepted op
module shift_add_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [2*N-1:0] add_sum,
    output logic [2*N-1:0] add_a,
    output logic [2*N-1:0] add_b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [2*N-1:0]  acc, mcand;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   cnt;
    logic            last;

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                // start has priority over abort here: abort is only
                // meaningful once an operation is running.
                if (start) state_d = RUN;
            end
            RUN: begin
                add_a = acc;
                add_b = mplier[0] ? mcand : '0;
                if (abort)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{N{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // On an abort the datapath is frozen and product keeps
                    // its previous value.
                    if (!abort) begin
                        acc    <= add_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        // add_sum on the last edge is the final accumulator,
                        // so product is valid on entry to DONE.
                        if (last) product <= add_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
